// File: rtl/keccak_target_check.sv
// Digest-vs-target comparator for a Keccak mining pipeline.
// Tags digests with nonces and buffers hits in a small FIFO.
module keccak_target_check #(
  parameter int NONCE_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NONCE_WIDTH-1:0] start_nonce,
  input  logic [255:0]           target,
  input  logic [255:0]           hash_in,
  input  logic                   hash_valid,
  output logic [NONCE_WIDTH-1:0] found_nonce,
  output logic                   found_valid,
  input  logic                   found_ready,
  output logic [31:0]            hash_count,
  output logic [15:0]            drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  logic [NONCE_WIDTH-1:0] nonce_ctr;
  logic                   s1_hit;
  logic [NONCE_WIDTH-1:0] s1_nonce;

  logic [NONCE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;

  logic accept;
  logic hit;
  logic push_req;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // A digest coinciding with start belongs to no scan and is ignored.
  assign accept   = hash_valid & ~start;
  assign hit      = hash_in <= target;
  assign push_req = s1_hit & ~start;
  assign full     = count == DEPTH;
  assign pop      = found_valid & found_ready;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // Outputs derive only from registers; empty FIFO shows zero.
  assign found_valid = count != '0;
  assign found_nonce = found_valid ? mem[rd_ptr] : '0;

  // Nonce counter and digest counter track the current scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      nonce_ctr  <= '0;
      hash_count <= '0;
    end else if (start) begin
      nonce_ctr  <= start_nonce;
      hash_count <= '0;
    end else if (accept) begin
      nonce_ctr  <= nonce_ctr + 1'b1;
      hash_count <= hash_count + 32'd1;
    end
  end

  // Stage 1: registered compare result with its nonce tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hit   <= 1'b0;
      s1_nonce <= '0;
    end else begin
      s1_hit   <= accept & hit;
      s1_nonce <= nonce_ctr;
    end
  end

  // FIFO storage; contents are masked at the output when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s1_nonce;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of hits lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_keccak_target_check.sv
// Self-checking bench for keccak_target_check.
// Expected hit nonces are queued at stimulus time and popped on output.
module tb_keccak_target_check;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  start_nonce;
  logic [255:0] target;
  logic [255:0] hash_in;
  logic         hash_valid;
  logic [31:0]  found_nonce;
  logic         found_valid;
  logic         found_ready;
  logic [31:0]  hash_count;
  logic [15:0]  drop_count;

  int pass_cnt = 0;
  int total    = 0;

  logic [31:0]  q [$];
  logic [31:0]  mn;
  logic [255:0] t240;
  logic [255:0] ones;

  always #5 clk = ~clk;

  keccak_target_check #(
    .NONCE_WIDTH(32),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .start_nonce(start_nonce),
    .target(target),
    .hash_in(hash_in),
    .hash_valid(hash_valid),
    .found_nonce(found_nonce),
    .found_valid(found_valid),
    .found_ready(found_ready),
    .hash_count(hash_count),
    .drop_count(drop_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    hash_valid = 1'b0;
    found_ready = 1'b0;
    tick();
    rst = 1'b0;
    q.delete();
    mn = 32'd0;
  endtask

  task automatic do_start(input logic [31:0] n);
    start = 1'b1;
    start_nonce = n;
    tick();
    start = 1'b0;
    mn = n;
  endtask

  task automatic send(input logic [255:0] h, input bit keep);
    hash_valid = 1'b1;
    hash_in = h;
    if (h <= target && keep) q.push_back(mn);
    mn = mn + 32'd1;
    tick();
    hash_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    logic [31:0] exp;
    found_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk);
      if (found_valid) begin
        exp = q.pop_front();
        total++;
        if (found_nonce !== exp)
          $display("FAIL %s_nonce got %h exp %h", name, found_nonce, exp);
        else
          pass_cnt++;
      end
      tick();
    end
    if (q.size() != 0) begin
      total++;
      $display("FAIL %s_timeout got %0d left exp 0", name, q.size());
      q.delete();
    end
    @(negedge clk);
    total++;
    if (found_valid !== 1'b0)
      $display("FAIL %s_empty got %b exp 0", name, found_valid);
    else
      pass_cnt++;
    found_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if (found_valid !== 1'b0) $display("FAIL rst_fv got %b exp 0", found_valid);
    else pass_cnt++;
    total++;
    if (found_nonce !== 32'd0) $display("FAIL rst_fn got %h exp 0", found_nonce);
    else pass_cnt++;
    total++;
    if (hash_count !== 32'd0) $display("FAIL rst_hc got %0d exp 0", hash_count);
    else pass_cnt++;
    total++;
    if (drop_count !== 16'd0) $display("FAIL rst_dc got %0d exp 0", drop_count);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_basic();
    target = t240;
    do_start(32'h100);
    hash_valid = 1'b1;
    hash_in = t240 << 1;
    mn = mn + 32'd1;
    tick();
    hash_in = t240 >> 1;
    q.push_back(mn);
    mn = mn + 32'd1;
    tick();
    hash_in = t240;
    q.push_back(mn);
    mn = mn + 32'd1;
    @(negedge clk);
    total++;
    if (found_valid !== 1'b0) $display("FAIL basic_early got %b exp 0", found_valid);
    else pass_cnt++;
    tick();
    hash_valid = 1'b0;
    @(negedge clk);
    total++;
    if (found_valid !== 1'b1) $display("FAIL basic_lat got %b exp 1", found_valid);
    else pass_cnt++;
    tick();
    drain("basic");
    total++;
    if (hash_count !== 32'd3) $display("FAIL basic_hc got %0d exp 3", hash_count);
    else pass_cnt++;
  endtask

  task automatic test_full_drop();
    target = ones;
    found_ready = 1'b0;
    do_start(32'h200);
    for (int i = 0; i < 6; i++) send(256'd0, i < 4);
    tick();
    tick();
    tick();
    @(negedge clk);
    total++;
    if (drop_count !== 16'd2) $display("FAIL full_dc got %0d exp 2", drop_count);
    else pass_cnt++;
    total++;
    if (hash_count !== 32'd6) $display("FAIL full_hc got %0d exp 6", hash_count);
    else pass_cnt++;
    tick();
    drain("full");
  endtask

  task automatic test_wrap();
    target = ones;
    do_start(32'hFFFF_FFFF);
    send(256'd0, 1'b1);
    send(256'd0, 1'b1);
    drain("wrap");
  endtask

  task automatic test_start_collide();
    target = ones;
    start = 1'b1;
    start_nonce = 32'd5;
    hash_valid = 1'b1;
    hash_in = 256'd0;
    tick();
    start = 1'b0;
    hash_valid = 1'b0;
    mn = 32'd5;
    tick();
    tick();
    @(negedge clk);
    total++;
    if (found_valid !== 1'b0) $display("FAIL coll_fv got %b exp 0", found_valid);
    else pass_cnt++;
    total++;
    if (hash_count !== 32'd0) $display("FAIL coll_hc got %0d exp 0", hash_count);
    else pass_cnt++;
    tick();
    send(256'd0, 1'b1);
    drain("coll");
    total++;
    if (hash_count !== 32'd1) $display("FAIL coll_hc1 got %0d exp 1", hash_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit stale;
    target = ones;
    found_ready = 1'b0;
    do_start(32'h400);
    send(256'd0, 1'b1);
    send(256'd0, 1'b1);
    hash_valid = 1'b1;
    hash_in = 256'd0;
    tick();
    @(negedge clk);
    total++;
    if (found_valid !== 1'b1) $display("FAIL rmid_pre got %b exp 1", found_valid);
    else pass_cnt++;
    rst = 1'b1;
    start = 1'b1;
    start_nonce = 32'h999;
    found_ready = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    hash_valid = 1'b0;
    q.delete();
    mn = 32'd0;
    @(negedge clk);
    total++;
    if (found_valid !== 1'b0) $display("FAIL rmid_fv got %b exp 0", found_valid);
    else pass_cnt++;
    total++;
    if (drop_count !== 16'd0) $display("FAIL rmid_dc got %0d exp 0", drop_count);
    else pass_cnt++;
    total++;
    if (hash_count !== 32'd0) $display("FAIL rmid_hc got %0d exp 0", hash_count);
    else pass_cnt++;
    stale = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      if (found_valid !== 1'b0) stale = 1'b1;
    end
    total++;
    if (stale) $display("FAIL rmid_stale got 1 exp 0");
    else pass_cnt++;
    found_ready = 1'b0;
    tick();
    send(256'd0, 1'b1);
    drain("rmid");
  endtask

  task automatic test_full_pushpop();
    logic [31:0] exp;
    do_reset();
    target = ones;
    do_start(32'h300);
    for (int i = 0; i < 4; i++) send(256'd0, 1'b1);
    tick();
    tick();
    @(negedge clk);
    total++;
    if (found_valid !== 1'b1) $display("FAIL pp_full got %b exp 1", found_valid);
    else pass_cnt++;
    tick();
    hash_valid = 1'b1;
    hash_in = 256'd0;
    tick();
    hash_valid = 1'b0;
    found_ready = 1'b1;
    @(negedge clk);
    exp = q.pop_front();
    total++;
    if (found_nonce !== exp) $display("FAIL pp_head got %h exp %h", found_nonce, exp);
    else pass_cnt++;
    q.push_back(mn);
    mn = mn + 32'd1;
    tick();
    found_ready = 1'b0;
    @(negedge clk);
    total++;
    if (drop_count !== 16'd0) $display("FAIL pp_dc got %0d exp 0", drop_count);
    else pass_cnt++;
    total++;
    if (found_nonce !== q[0]) $display("FAIL pp_next got %h exp %h", found_nonce, q[0]);
    else pass_cnt++;
    tick();
    drain("pp");
    total++;
    if (hash_count !== 32'd5) $display("FAIL pp_hc got %0d exp 5", hash_count);
    else pass_cnt++;
  endtask

  initial begin
    t240 = 256'd1 << 240;
    ones = '1;
    rst = 1'b1;
    start = 1'b0;
    start_nonce = 32'd0;
    target = '0;
    hash_in = '0;
    hash_valid = 1'b0;
    found_ready = 1'b0;
    mn = 32'd0;
    test_reset();
    test_basic();
    test_full_drop();
    test_wrap();
    test_start_collide();
    test_reset_mid();
    test_full_pushpop();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/keccak_target_check.md
KECCAK_TARGET_CHECK -- requirements
Module: keccak_target_check

Interface
REQ-001 SHALL have parameter NONCE_WIDTH, default 32, width of nonce tracking and reporting.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of hit entries buffered; power of two, minimum 2.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that loads start_nonce and begins a new scan.
REQ-007 SHALL have port start_nonce  input  NONCE_WIDTH  nonce of the first hash after start.
REQ-008 SHALL have port target  input  256  unsigned threshold; held stable during a scan.
REQ-009 SHALL have port hash_in  input  256  hasher digest; bit 255 is the MSB.
REQ-010 SHALL have port hash_valid  input  1  digest-valid strobe, driven by the hasher write output.
REQ-011 SHALL have port found_nonce  output  NONCE_WIDTH  nonce at the FIFO head.
REQ-012 SHALL have port found_valid  output  1  FIFO non-empty.
REQ-013 SHALL have port found_ready  input  1  consumer pops the head when found_valid is also high.
REQ-014 SHALL have port hash_count  output  32  digests checked since the last start.
REQ-015 SHALL have port drop_count  output  16  hits lost because the FIFO was full.

Function
REQ-016 SHALL hold nonce_ctr; start loads start_nonce; each accepted hash_valid increments it modulo 2^NONCE_WIDTH.
REQ-017 SHALL tag each accepted digest with the nonce_ctr value in its hash_valid cycle; digests arrive in issue order, one nonce each.
REQ-018 SHALL discard a hash_valid coinciding with start: no compare, no count, no increment; start wins.
REQ-019 SHALL declare a hit when hash_in <= target as 256-bit unsigned; equality is a hit.
REQ-020 SHALL register compare result and tagged nonce in stage 1 (cycle N+1 for hash_valid at N).
REQ-021 SHALL push stage-1 hits into the FIFO at the next edge; found_valid rises at N+2 at the earliest when the FIFO was empty.
REQ-022 SHALL accept a hash_valid every cycle (full throughput), with no backpressure toward the hasher.
REQ-023 SHALL clear the stage-1 valid bit on start, so an in-flight compare is discarded; FIFO contents are retained.
REQ-024 SHALL pop the FIFO on found_valid and found_ready; found_nonce shows the oldest entry, first-word order.
REQ-025 SHALL, on push when full with no pop, drop the new hit and increment drop_count, saturating at 0xFFFF.
REQ-026 SHALL, on push and pop in the same cycle while full, accept both; no drop, occupancy unchanged.
REQ-027 SHALL, on push and pop in the same cycle while occupancy is 1, keep found_valid high and present the new entry next cycle.
REQ-028 SHALL ignore found_ready when the FIFO is empty; no underflow, pointers unchanged.
REQ-029 SHALL increment hash_count on each accepted digest, wrapping modulo 2^32; start clears it to 0.
REQ-030 SHALL register all outputs; no combinational path from any input to any output.

Reset
REQ-031 SHALL, while rst is high, clear nonce_ctr, stage-1 valid, FIFO pointers and occupancy, hash_count and drop_count.
REQ-032 SHALL drive found_valid=0, found_nonce=0, hash_count=0, drop_count=0 in the cycle after rst is sampled high.
REQ-033 SHALL give rst priority over start, hash_valid and found_ready in the same cycle.
REQ-034 SHALL discard all in-flight and buffered hits on reset mid-scan.

Verification
REQ-035 SHALL cover: start with start_nonce=0x100, target=2^240, then 3 hash_valid with hash_in=2^241, 2^239, 2^240 -> found nonces 0x101 then 0x102, first found_valid 2 cycles after the second strobe, hash_count=3.
REQ-036 SHALL cover: found_ready=0, 6 consecutive hits -> FIFO holds 4 entries (nonces start..start+3), drop_count=2; then found_ready=1 -> the 4 entries pop in order.
REQ-037 SHALL cover: start_nonce=0xFFFFFFFF, 2 hits -> found nonces 0xFFFFFFFF then 0x00000000.
REQ-038 SHALL cover: start and hash_valid (hit) in the same cycle, with start_nonce=5 -> no FIFO push, hash_count=0, and the next digest is tagged 5.
REQ-039 SHALL cover: FIFO full plus a hit, with push and pop in the same cycle -> drop_count unchanged and occupancy stays 4.
REQ-040 SHALL cover: rst during a burst with 2 entries buffered -> found_valid=0, drop_count=0 and hash_count=0 next cycle, with no stale output after release.
